demux_stream_1ton: RTL and testbench
====================================

Name: demux_stream_1toN

Overview:
- Parametrised, registered 1-to-N demultiplexer with a valid/ready handshake on the input and on every output channel.
- Successor to the combinational 1-to-8 demux family: generalised in data width and channel count, with one register slot per channel and per-channel back-pressure.
- Sits between a single producer and N independent consumers, for example in command or packet routing.

Parameters:
- WIDTH, 8, data width in bits of the input and of each output channel.
- NCH, 8, number of output channels; legal range 2..64.
- SNUM, $clog2(NCH), select width; derived, not overridden.

Ports:
- clk  input  1  single clock; rising edge.
- rst  input  1  reset; asynchronous, active-high.
- i  input  WIDTH  input data.
- sel  input  SNUM  destination channel index.
- i_valid  input  1  input word valid.
- i_ready  output  1  block can accept the input word this cycle.
- o  output  NCH*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- o_valid  output  NCH  per-channel data valid.
- o_ready  input  NCH  per-channel consumer ready.
- err  output  1  one-cycle pulse on an accepted word whose sel >= NCH.

Behaviour:
- Reset (asynchronous): o=0, o_valid=0, err=0. i_ready is forced to 0 while rst=1.
- Each channel k has one slot register holding data and a valid flag.
- Input acceptance, for sel < NCH: i_ready = !o_valid[sel] | o_ready[sel]. This gives pass-through when the slot drains in the same cycle.
- Input acceptance, for sel >= NCH (only possible when NCH is not a power of two): i_ready=1. The word is accepted and discarded, and err=1 on the next cycle for exactly one cycle.
- Transfer: i_valid & i_ready at edge t. Then o[sel] = i and o_valid[sel] = 1 from t+1. Latency is 1 cycle.
- Drain: o_valid[k] & o_ready[k] at edge t. Then o_valid[k] = 0 at t+1, unless channel k is reloaded at the same edge, in which case it stays 1 with the new data.
- Independence: draining or stalling one channel never affects any other channel. Full throughput of 1 word/cycle is available to any channel whose consumer holds o_ready=1.
- o[k] holds its last value while o_valid[k]=0. It is not cleared on drain.
- Input protocol rule: i and sel stay stable while i_valid=1 and i_ready=0. The bench checks this; the RTL does not.
- i_ready is combinational from sel, o_valid and o_ready. There is no combinational path from i_valid to i_ready.
- Reset mid-operation: all pending slot contents are lost and o_valid clears immediately.

Optional Feature:
- Macro: DEMUX_BCAST_EN.
- With the macro defined:
  - Adds input port i_bcast (1 bit).
  - When i_bcast=1, sel is ignored and i_ready = AND over k of (!o_valid[k] | o_ready[k]).
  - On acceptance, every channel loads i and sets o_valid at t+1.
  - err is never raised for a broadcast word.
- Without the macro: the port does not exist and only unicast routing is present.

Decomposition:
- Package demux_pkg holds:
  - the default width/channel constants;
  - the clog2 helper function;
  - the channel-slice helper (index k to bit offset).
- One natural sub-module, demux_slot:
  - one WIDTH-bit register plus valid flag;
  - inputs load, din, ready; outputs dout, valid;
  - instantiated NCH times in a generate loop.
- The top level keeps the sel decode, the i_ready mux and the err register.

Test Plan:
- Reset: assert rst mid-transfer with o_valid=8'h0F. Expect o_valid=0, o=0 and i_ready=0 immediately, asynchronously. After release, i_ready=1.
- Sweep: all o_ready=1; send i=8'hA0..8'hA7 on sel=0..7, one per cycle. Expect o[k]=8'hA0+k with o_valid[k]=1 exactly one cycle after each acceptance, and no gaps.
- Back-pressure: o_ready[3]=0; send 8'hB0 then 8'hB1 to sel=3. Expect the first word accepted, then i_ready=0 on the second with o[3]=8'hB0 held. Raise o_ready[3]; the second word is accepted in that same cycle and o[3]=8'hB1 on the next cycle.
- Independence: channel 3 is stalled full; send 8'hC5 to sel=5. Expect it accepted immediately and o[5]=8'hC5 next cycle, while channel 3 is unchanged.
- Out of range: NCH=6 (SNUM=3); send 8'hDD with sel=7. Expect i_ready=1, err high for exactly one cycle, and no o_valid change.
- With DEMUX_BCAST_EN, NCH=4: channel 2 is full and its o_ready=0; send i_bcast=1, i=8'hEE. Expect i_ready=0. Drop o_valid[2] by raising o_ready[2]; the word is accepted and all four channels show 8'hEE with o_valid=4'hF next cycle.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the registered 1-to-N stream demultiplexer.
package demux_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_NCH   = 8;

   function automatic int clog2(input int n);
      int r = 0;
      for (int b = 0; b < 31; b++) begin
         if ((1 << b) < n) r = b + 1;
      end
      return r;
   endfunction

   // Channel k's data occupies [k*w +: w] of the packed output bus.
   function automatic int slice_lo(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/demux_slot.sv
// One channel slot: a data register plus valid flag, loaded by the router and drained by its consumer.
module demux_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             ready,
   output logic [WIDTH-1:0] dout,
   output logic             valid
);

   logic [WIDTH-1:0] data_p1;
   logic             vld_p1;

   // Stage p1: data is kept after a drain; only the flag clears.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_p1 <= '0;
         vld_p1  <= 1'b0;
      end else if (load) begin
         data_p1 <= din;
         vld_p1  <= 1'b1;
      end else if (vld_p1 && ready) begin
         vld_p1  <= 1'b0;
      end
   end

   assign dout  = data_p1;
   assign valid = vld_p1;

endmodule

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-NCH stream demux with per-channel valid/ready back-pressure.
// Optional broadcast input i_bcast is enabled by defining DEMUX_BCAST_EN.
module demux_stream_1ton
   import demux_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int NCH   = DEF_NCH,
   localparam int SNUM  = clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     i,
   input  logic [SNUM-1:0]      sel,
   input  logic                 i_valid,
   output logic                 i_ready,
   output logic [NCH*WIDTH-1:0] o,
   output logic [NCH-1:0]       o_valid,
   input  logic [NCH-1:0]       o_ready,
   output logic                 err
`ifdef DEMUX_BCAST_EN
   ,
   input  logic                 i_bcast
`endif
);

   localparam int SPAN = 1 << SNUM;

   logic            bcast;
   logic            in_range;
   logic            accept;
   logic [NCH-1:0]  slot_free;
   logic [NCH-1:0]  load;
   logic [SPAN-1:0] free_ext;

`ifdef DEMUX_BCAST_EN
   assign bcast = i_bcast;
`else
   assign bcast = 1'b0;
`endif

   assign slot_free = ~o_valid | o_ready;

   generate
      if (SPAN == NCH) begin : g_pow2
         assign in_range = 1'b1;
      end else begin : g_npow2
         assign in_range = ({1'b0, sel} < (SNUM + 1)'(NCH));
      end
   endgenerate

   // Pad to the full select span so out-of-range indices never address past the vector.
   always_comb begin
      free_ext            = '0;
      free_ext[NCH-1:0]   = slot_free;
   end

   always_comb begin
      i_ready = 1'b0;
      if (rst)           i_ready = 1'b0;
      else if (bcast)    i_ready = &slot_free;
      else if (in_range) i_ready = free_ext[sel];
      else               i_ready = 1'b1;
   end

   assign accept = i_valid & i_ready;

   generate
      for (genvar k = 0; k < NCH; k++) begin : g_ch
         assign load[k] = accept & (bcast | (in_range & (sel == SNUM'(k))));

         demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load[k]),
            .din   (i),
            .ready (o_ready[k]),
            .dout  (o[slice_lo(k, WIDTH) +: WIDTH]),
            .valid (o_valid[k])
         );
      end
   endgenerate

   // Stage p1: discarded out-of-range words flag a single-cycle error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err <= 1'b0;
      else     err <= accept & ~bcast & ~in_range;
   end

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Directed bench for demux_stream_1ton: NCH=8 main instance, NCH=6 for out-of-range select,
// and an NCH=4 broadcast instance when DEMUX_BCAST_EN is defined.
module tb_demux_stream_1ton;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   logic [7:0]  i8 = '0;
   logic [2:0]  sel8 = '0;
   logic        iv8 = 1'b0;
   logic        ir8;
   logic [63:0] o8;
   logic [7:0]  ov8;
   logic [7:0]  ordy8 = '0;
   logic        err8;

   logic [7:0]  i6 = '0;
   logic [2:0]  sel6 = '0;
   logic        iv6 = 1'b0;
   logic        ir6;
   logic [47:0] o6;
   logic [5:0]  ov6;
   logic [5:0]  ordy6 = '0;
   logic        err6;

   demux_stream_1ton #(.WIDTH(8), .NCH(8)) dut (
      .clk(clk), .rst(rst), .i(i8), .sel(sel8), .i_valid(iv8), .i_ready(ir8),
      .o(o8), .o_valid(ov8), .o_ready(ordy8), .err(err8)
`ifdef DEMUX_BCAST_EN
      , .i_bcast(1'b0)
`endif
   );

   demux_stream_1ton #(.WIDTH(8), .NCH(6)) dut6 (
      .clk(clk), .rst(rst), .i(i6), .sel(sel6), .i_valid(iv6), .i_ready(ir6),
      .o(o6), .o_valid(ov6), .o_ready(ordy6), .err(err6)
`ifdef DEMUX_BCAST_EN
      , .i_bcast(1'b0)
`endif
   );

`ifdef DEMUX_BCAST_EN
   logic [7:0]  ib = '0;
   logic [1:0]  selb = '0;
   logic        ivb = 1'b0;
   logic        irb;
   logic [31:0] ob;
   logic [3:0]  ovb;
   logic [3:0]  ordyb = '0;
   logic        errb;
   logic        bcb = 1'b0;

   demux_stream_1ton #(.WIDTH(8), .NCH(4)) dutb (
      .clk(clk), .rst(rst), .i(ib), .sel(selb), .i_valid(ivb), .i_ready(irb),
      .o(ob), .o_valid(ovb), .o_ready(ordyb), .err(errb), .i_bcast(bcb)
   );
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Producer-side rule: while a word is held off, its data and select must not move.
   logic       pend8 = 1'b0;
   logic [7:0] pi8 = '0;
   logic [2:0] psel8 = '0;
   always @(negedge clk) begin
      if (pend8) begin
         chk("proto_i", 64'(i8), 64'(pi8));
         chk("proto_sel", 64'(sel8), 64'(psel8));
      end
      pend8 = iv8 & ~ir8 & ~rst;
      pi8   = i8;
      psel8 = sel8;
   end

   initial begin
      repeat (2) tick();
      chk("rst_ov", 64'(ov8), 64'h0);
      chk("rst_o", o8, 64'h0);
      chk("rst_ir", 64'(ir8), 64'h0);
      chk("rst_err", 64'(err8), 64'h0);
      rst = 1'b0;
      #1;
      chk("rel_ir", 64'(ir8), 64'h1);

      // Sweep every channel at full rate with all consumers ready.
      ordy8 = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         i8 = 8'hA0 + 8'(k);
         sel8 = 3'(k);
         iv8 = 1'b1;
         #1;
         chk("sweep_ir", 64'(ir8), 64'h1);
         tick();
         chk("sweep_ov", 64'(ov8), 64'h1 << k);
         chk("sweep_o", 64'(o8[k*8 +: 8]), 64'hA0 + 64'(k));
      end
      iv8 = 1'b0;
      tick();
      chk("sweep_drain_ov", 64'(ov8), 64'h0);
      chk("sweep_hold_o", o8, 64'hA7A6A5A4A3A2A1A0);

      // Fill channels 0..3 with consumers stalled, then reset mid-transfer.
      ordy8 = 8'h00;
      for (int k = 0; k < 4; k++) begin
         i8 = 8'h10 + 8'(k);
         sel8 = 3'(k);
         iv8 = 1'b1;
         tick();
      end
      chk("fill_ov", 64'(ov8), 64'h0F);
      i8 = 8'h55;
      sel8 = 3'd4;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_ov", 64'(ov8), 64'h0);
      chk("async_rst_o", o8, 64'h0);
      chk("async_rst_ir", 64'(ir8), 64'h0);
      #2;
      rst = 1'b0;
      iv8 = 1'b0;
      #1;
      chk("rel2_ir", 64'(ir8), 64'h1);
      tick();

      // Back-pressure on channel 3, with channel 5 flowing independently.
      ordy8 = 8'hF7;
      i8 = 8'hB0;
      sel8 = 3'd3;
      iv8 = 1'b1;
      #1;
      chk("bp_first_ir", 64'(ir8), 64'h1);
      tick();
      chk("bp_first_o3", 64'(o8[31:24]), 64'hB0);
      chk("bp_first_ov", 64'(ov8), 64'h08);
      i8 = 8'hC5;
      sel8 = 3'd5;
      #1;
      chk("ind_ir", 64'(ir8), 64'h1);
      tick();
      chk("ind_ov", 64'(ov8), 64'h28);
      chk("ind_o5", 64'(o8[47:40]), 64'hC5);
      chk("ind_o3", 64'(o8[31:24]), 64'hB0);
      i8 = 8'hB1;
      sel8 = 3'd3;
      #1;
      chk("bp_stall_ir", 64'(ir8), 64'h0);
      tick();
      chk("bp_stall_o3", 64'(o8[31:24]), 64'hB0);
      chk("bp_stall_ov", 64'(ov8), 64'h08);
      ordy8 = 8'hFF;
      #1;
      chk("bp_pass_ir", 64'(ir8), 64'h1);
      tick();
      chk("bp_reload_o3", 64'(o8[31:24]), 64'hB1);
      chk("bp_reload_ov", 64'(ov8), 64'h08);
      iv8 = 1'b0;
      tick();
      chk("bp_drain_ov", 64'(ov8), 64'h0);
      chk("bp_hold_o3", 64'(o8[31:24]), 64'hB1);

      // Back-to-back words into one channel.
      i8 = 8'hE0;
      sel8 = 3'd2;
      iv8 = 1'b1;
      tick();
      chk("tput0_o2", 64'(o8[23:16]), 64'hE0);
      i8 = 8'hE1;
      #1;
      chk("tput1_ir", 64'(ir8), 64'h1);
      tick();
      chk("tput1_o2", 64'(o8[23:16]), 64'hE1);
      chk("tput1_ov", 64'(ov8), 64'h04);
      iv8 = 1'b0;
      chk("no_err8", 64'(err8), 64'h0);

      // NCH=6: out-of-range select is accepted, discarded and flagged.
      ordy6 = 6'h00;
      i6 = 8'h66;
      sel6 = 3'd1;
      iv6 = 1'b1;
      tick();
      chk("oor_load_ov", 64'(ov6), 64'h02);
      iv6 = 1'b0;
      #1;
      chk("oor_stall_ir", 64'(ir6), 64'h0);
      i6 = 8'hDD;
      sel6 = 3'd7;
      iv6 = 1'b1;
      #1;
      chk("oor_ir", 64'(ir6), 64'h1);
      chk("oor_err_pre", 64'(err6), 64'h0);
      tick();
      chk("oor_err", 64'(err6), 64'h1);
      chk("oor_ov", 64'(ov6), 64'h02);
      chk("oor_o", 64'(o6), 64'h0000_0000_6600);
      iv6 = 1'b0;
      tick();
      chk("oor_err_off", 64'(err6), 64'h0);
      chk("oor_ov_after", 64'(ov6), 64'h02);

`ifdef DEMUX_BCAST_EN
      // Broadcast waits for every slot, then loads all of them.
      ordyb = 4'h0;
      ib = 8'h22;
      selb = 2'd2;
      ivb = 1'b1;
      tick();
      chk("bc_fill_ov", 64'(ovb), 64'h4);
      ib = 8'hEE;
      bcb = 1'b1;
      #1;
      chk("bc_block_ir", 64'(irb), 64'h0);
      tick();
      chk("bc_block_ov", 64'(ovb), 64'h4);
      ordyb = 4'h4;
      #1;
      chk("bc_pass_ir", 64'(irb), 64'h1);
      tick();
      chk("bc_o", 64'(ob), 64'hEEEEEEEE);
      chk("bc_ov", 64'(ovb), 64'hF);
      chk("bc_err", 64'(errb), 64'h0);
      ivb = 1'b0;
      bcb = 1'b0;
`endif

      tick();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
